// File: rtl/act_pkg.sv
// Shared types and helpers for the activation-unit datapath.
// Holds the tensor FSM encoding and IEEE-754 single NaN helpers.
package act_pkg;

    localparam int ACT_DATA_W = 32;
    localparam logic [ACT_DATA_W-1:0] ACT_QNAN = 32'h7FC0_0000;

    typedef enum logic [0:0] {
        TS_IDLE      = 1'b0,
        TS_IN_TENSOR = 1'b1
    } tensor_state_t;

    // NaN: all-ones exponent with a non-zero mantissa
    function automatic logic act_is_nan(input logic [ACT_DATA_W-1:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/act_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy counter.
// Caller guarantees push only when !full||pop and pop only when !empty.
module act_sync_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // storage array, written on accepted pushes
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // occupancy: simultaneous push and pop leave it unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/selu_out_collector.sv
// SELU output collector: FIFO-buffers the SELU stream and tags tensor ends.
// Optional NaN canonicalisation under SELU_COLLECT_NAN_CANON_EN.
module selu_out_collector
    import act_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 16,
    parameter int TLEN_W       = 16,
    parameter int AFULL_MARGIN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] input_data,
    input  logic [TLEN_W-1:0] tensor_len,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              almost_full,
    input  logic              clear_ovf,
    output logic              overflow,
    output logic              nan_seen
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]     AF_TH = CW'(DEPTH - AFULL_MARGIN);
    localparam logic [TLEN_W-1:0] ONE   = TLEN_W'(1);

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              drop;
    logic [CW-1:0]     occ;
    logic [DATA_W:0]   wr_ent;
    logic [DATA_W:0]   rd_ent;
    logic [DATA_W-1:0] wr_data;
    logic              last_tag;
    logic [TLEN_W-1:0] len_eff;

    tensor_state_t     state_q;
    tensor_state_t     state_d;
    logic [TLEN_W-1:0] len_q;
    logic [TLEN_W-1:0] len_d;
    logic [TLEN_W-1:0] cnt_q;
    logic [TLEN_W-1:0] cnt_d;
    logic              ovf_q;

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign push      = valid_in && (!full || pop);
    assign drop      = valid_in && full && !pop;
    assign len_eff   = (tensor_len == '0) ? ONE : tensor_len;
    assign wr_ent    = {last_tag, wr_data};

    act_sync_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wr_ent),
        .rdata (rd_ent),
        .full  (full),
        .empty (empty),
        .count (occ)
    );

    assign out_data    = out_valid ? rd_ent[DATA_W-1:0] : '0;
    assign out_last    = out_valid && rd_ent[DATA_W];
    assign almost_full = (occ >= AF_TH);
    assign overflow    = ovf_q;

    // tensor FSM state and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TS_IDLE;
            len_q   <= ONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // next state and last tagging; only accepted pushes advance it
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        last_tag = 1'b0;
        unique case (state_q)
            TS_IDLE: begin
                last_tag = (len_eff == ONE);
                if (push) begin
                    len_d = len_eff;
                    if (len_eff == ONE) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d   = ONE;
                        state_d = TS_IN_TENSOR;
                    end
                end
            end
            TS_IN_TENSOR: begin
                last_tag = (cnt_q == len_q - ONE);
                if (push) begin
                    if (last_tag) begin
                        cnt_d   = '0;
                        state_d = TS_IDLE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            default: begin
                state_d = TS_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // sticky overflow; a drop wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (clear_ovf) begin
            ovf_q <= 1'b0;
        end
    end

`ifdef SELU_COLLECT_NAN_CANON_EN
    logic nan_push;
    logic nan_q;

    assign nan_push = act_is_nan(ACT_DATA_W'(input_data));
    assign wr_data  = nan_push ? DATA_W'(ACT_QNAN) : input_data;
    assign nan_seen = nan_q;

    // sticky NaN flag; a NaN push wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nan_q <= 1'b0;
        end else if (push && nan_push) begin
            nan_q <= 1'b1;
        end else if (clear_ovf) begin
            nan_q <= 1'b0;
        end
    end
`else
    assign wr_data  = input_data;
    assign nan_seen = 1'b0;
`endif

endmodule

// File: tb/tb_selu_out_collector.sv
// Self-checking bench for selu_out_collector.
// Table vectors, directed corner sequences and a queue-based random model.
module tb_selu_out_collector;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int TW    = 16;
    localparam int AFM   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_in = 1'b0;
    logic [DW-1:0] input_data = '0;
    logic [TW-1:0] tensor_len = '0;
    logic          out_ready = 1'b0;
    logic          clear_ovf = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          almost_full;
    logic          overflow;
    logic          nan_seen;

    selu_out_collector #(
        .DATA_W       (DW),
        .DEPTH        (DEPTH),
        .TLEN_W       (TW),
        .AFULL_MARGIN (AFM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .input_data  (input_data),
        .tensor_len  (tensor_len),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .almost_full (almost_full),
        .clear_ovf   (clear_ovf),
        .overflow    (overflow),
        .nan_seen    (nan_seen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          last;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct {
        logic          vin;
        logic [DW-1:0] d;
        logic [TW-1:0] tl;
        logic          rdy;
        logic          ev;
        logic [DW-1:0] ed;
        logic          el;
    } vec_t;

    ent_t q[$];
    vec_t vt[$];
    int   m_pos;
    int   m_len;
    bit   m_ovf;
    bit   m_nan;
    int   n_tests;
    int   n_fail;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    task automatic check_model();
        logic [31:0] ed;
        logic        el;
        ed = 0;
        el = 0;
        if (q.size() > 0) begin
            ed = q[0].data;
            el = q[0].last;
        end
        chk("m_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("m_data", 64'(out_data), 64'(ed));
        chk("m_last", 64'(out_last), 64'(el));
        chk("m_afull", 64'(almost_full), 64'(q.size() >= DEPTH - AFM));
        chk("m_ovf", 64'(overflow), 64'(m_ovf));
        chk("m_nan", 64'(nan_seen), 64'(m_nan));
    endtask

    task automatic model_step(input bit vin, input logic [31:0] d,
                              input int tl, input bit rdy, input bit clr);
        bit   pop;
        bit   push;
        bit   nanp;
        ent_t e;
        pop  = (q.size() > 0) && rdy;
        push = vin && ((q.size() < DEPTH) || pop);
        nanp = 0;
        if (pop) e = q.pop_front();
        if (push) begin
            if (m_pos == 0) m_len = (tl == 0) ? 1 : tl;
            m_pos++;
            e.last = (m_pos == m_len);
            if (e.last) m_pos = 0;
            e.data = d;
`ifdef SELU_COLLECT_NAN_CANON_EN
            if (is_nan(d)) begin
                e.data = 32'h7FC0_0000;
                nanp = 1;
            end
`endif
            q.push_back(e);
        end
        if (vin && !push) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (nanp) m_nan = 1;
        else if (clr) m_nan = 0;
    endtask

    // at a negedge: check, drive one cycle, advance model, next negedge
    task automatic cycle(input bit vin, input logic [31:0] d, input int tl,
                         input bit rdy, input bit clr);
        check_model();
        valid_in   = vin;
        input_data = d;
        tensor_len = TW'(tl);
        out_ready  = rdy;
        clear_ovf  = clr;
        model_step(vin, d, tl, rdy, clr);
        @(negedge clk);
    endtask

    task automatic add(input bit vin, input logic [31:0] d, input int tl,
                       input bit rdy, input bit ev, input logic [31:0] ed,
                       input bit el);
        vec_t v;
        v.vin = vin; v.d = d; v.tl = TW'(tl); v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.el = el;
        vt.push_back(v);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        chk("rst_last", 64'(out_last), 64'(0));
        chk("rst_afull", 64'(almost_full), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        chk("rst_nan", 64'(nan_seen), 64'(0));
        q.delete();
        m_pos = 0;
        m_len = 1;
        m_ovf = 0;
        m_nan = 0;
        valid_in  = 0;
        out_ready = 0;
        clear_ovf = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_pos   = 0;
        m_len   = 1;
        m_ovf   = 0;
        m_nan   = 0;
        #1;
        do_reset();

        // table: len 4 stream, len 0, then len 3 -> 5 mid tensor
        for (int i = 1; i <= 8; i++)
            add(1, 32'h100 + i, 4, 1, 1, 32'h100 + i, (i % 4) == 0);
        add(0, 0, 4, 1, 0, 0, 0);
        for (int i = 1; i <= 3; i++)
            add(1, 32'h200 + i, 0, 1, 1, 32'h200 + i, 1);
        add(1, 32'h301, 3, 1, 1, 32'h301, 0);
        for (int i = 2; i <= 8; i++)
            add(1, 32'h300 + i, 5, 1, 1, 32'h300 + i, i == 3 || i == 8);
        add(0, 0, 5, 1, 0, 0, 0);
        foreach (vt[i]) begin
            cycle(vt[i].vin, vt[i].d, vt[i].tl, vt[i].rdy, 0);
            chk("t_valid", 64'(out_valid), 64'(vt[i].ev));
            chk("t_data", 64'(out_data), 64'(vt[i].ed));
            chk("t_last", 64'(out_last), 64'(vt[i].el));
        end

        // fill to full with no drain; watch almost_full threshold
        for (int i = 1; i <= 16; i++) begin
            cycle(1, 32'hA00 + i, 16, 0, 0);
            if (i == 11) chk("af_at11", 64'(almost_full), 64'(0));
            if (i == 12) chk("af_at12", 64'(almost_full), 64'(1));
        end
        chk("ovf_before", 64'(overflow), 64'(0));
        cycle(1, 32'hBAD, 16, 0, 0);
        chk("ovf_drop", 64'(overflow), 64'(1));
        for (int i = 1; i <= 16; i++) begin
            chk("drain_v", 64'(out_valid), 64'(1));
            chk("drain_d", 64'(out_data), 64'(32'hA00 + i));
            chk("drain_l", 64'(out_last), 64'(i == 16));
            cycle(0, 0, 16, 1, 0);
        end
        chk("drain_empty", 64'(out_valid), 64'(0));
        cycle(0, 0, 4, 0, 1);
        chk("ovf_clear", 64'(overflow), 64'(0));

        // full with simultaneous push and pop
        for (int i = 1; i <= 16; i++) cycle(1, 32'hC00 + i, 4, 0, 0);
        cycle(1, 32'hC11, 4, 1, 0);
        chk("fullpp_ovf", 64'(overflow), 64'(0));
        chk("fullpp_af", 64'(almost_full), 64'(1));
        chk("fullpp_head", 64'(out_data), 64'(32'hC02));
        for (int i = 0; i < 17; i++) cycle(0, 0, 4, 1, 0);
        chk("fullpp_empty", 64'(out_valid), 64'(0));

        // reset mid-tensor with five entries queued
        for (int i = 1; i <= 5; i++) cycle(1, 32'hD00 + i, 7, 0, 0);
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            cycle(1, 32'hE00 + i, 3, 1, 0);
            chk("post_rst_l", 64'(out_last), 64'(i == 3));
        end
        cycle(0, 0, 3, 1, 0);

        // NaN and infinity, single-element tensors
        cycle(1, 32'h7F80_0001, 1, 1, 0);
`ifdef SELU_COLLECT_NAN_CANON_EN
        chk("nan_data", 64'(out_data), 64'(32'h7FC0_0000));
        chk("nan_flag", 64'(nan_seen), 64'(1));
`else
        chk("nan_data", 64'(out_data), 64'(32'h7F80_0001));
        chk("nan_flag", 64'(nan_seen), 64'(0));
`endif
        cycle(1, 32'h7F80_0000, 1, 1, 0);
        chk("inf_data", 64'(out_data), 64'(32'h7F80_0000));
        cycle(0, 0, 1, 1, 1);

        // random traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] d;
            d = $urandom;
            if ($urandom_range(0, 15) == 0) d = 32'h7F80_0000 | 32'($urandom_range(0, 3));
            cycle($urandom_range(0, 9) < 7, d, $urandom_range(0, 5),
                  $urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 4 : 8),
                  $urandom_range(0, 31) == 0);
        end
        for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, 0, 1, 0);
        check_model();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
